// File: rtl/elbeth_mux_arb.sv
// elbeth_mux_arb: registered NUM_CH-to-1 data selector with fixed-priority / round-robin arbitration
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid    packed channel words and per-channel requests
//   in_ready            one-hot (or zero) accept toward the granted channel
//   in_lock             hold the grant after this beat (only with ELBETH_MUX_ARB_LOCK_EN)
//   mode                0 = fixed priority (ch0 highest), 1 = round-robin
//   out_data/out_sel    registered winning word and its channel index
//   out_valid/out_ready output handshake
// Optional feature macro: ELBETH_MUX_ARB_LOCK_EN (burst lock on a channel).
module elbeth_mux_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH-1:0]            in_lock,
  input  logic                         mode,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]             out_sel,
  output logic                         out_valid,
  input  logic                         out_ready
);
  logic [SEL_W-1:0]      ptr_q, ptr_d, sel_q, sel_d, g, fix_g, rr_g;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, load, accept;
  // Descending scans so the last hit is the lowest index / first index from ptr.
  always_comb begin
    fix_g = '0;
    rr_g  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (in_valid[i]) fix_g = SEL_W'(i);
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (in_valid[(int'(ptr_q) + k) % NUM_CH]) rr_g = SEL_W'((int'(ptr_q) + k) % NUM_CH);
  end
`ifdef ELBETH_MUX_ARB_LOCK_EN
  logic             lock_active_q, lock_active_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  // A locked channel keeps the grant even while it is idle, stalling the others.
  assign g             = lock_active_q ? lock_ch_q : (mode ? rr_g : fix_g);
  assign lock_active_d = accept ? in_lock[g] : lock_active_q;
  assign lock_ch_d     = (accept && in_lock[g]) ? g : lock_ch_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_active_q <= 1'b0;
      lock_ch_q     <= '0;
    end else begin
      lock_active_q <= lock_active_d;
      lock_ch_q     <= lock_ch_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^in_lock;
  assign g = mode ? rr_g : fix_g;
`endif
  assign load     = !valid_q | out_ready;
  assign in_ready = (!rst && load && in_valid[g]) ? NUM_CH'(1) << g : '0;
  assign accept   = |in_ready;
  assign valid_d  = load ? accept : valid_q;
  assign data_d   = accept ? in_data[g*DATA_WIDTH +: DATA_WIDTH] : data_q;
  assign sel_d    = accept ? g : sel_q;
  assign ptr_d    = accept ? ((g == SEL_W'(NUM_CH - 1)) ? '0 : g + 1'b1) : ptr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;
endmodule

// File: tb/tb_elbeth_mux_arb.sv
// tb_elbeth_mux_arb: randomized and directed bench for elbeth_mux_arb against a queue-free behavioural model
module tb_elbeth_mux_arb;
  localparam int N = 4;
  localparam int W = 32;
  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready, in_lock;
  logic           mode, out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic [3*W-1:0] d3;
  logic [2:0]     v3, r3, l3;
  logic           mode3, ov3, or3;
  logic [W-1:0]   od3;
  logic [1:0]     s3;
  int checks = 0;
  int errors = 0;
  int m_ptr, m_sel, m_lock_ch, exp_g;
  bit m_lock, m_valid;
  logic [W-1:0] m_data;
  logic [N-1:0] exp_ready;

  elbeth_mux_arb #(.DATA_WIDTH(W), .NUM_CH(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_lock(in_lock), .mode(mode), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready));

  elbeth_mux_arb #(.DATA_WIDTH(W), .NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3),
    .in_lock(l3), .mode(mode3), .out_data(od3), .out_sel(s3),
    .out_valid(ov3), .out_ready(or3));

  always #5 clk = ~clk;

  // Reference arbitration: lock owner, else first valid channel in priority order.
  function automatic int model_grant();
    if (m_lock) return m_lock_ch;
    for (int k = 0; k < N; k++) begin
      int i = mode ? (m_ptr + k) % N : k;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic settle();
    #1;
    exp_g = model_grant();
    exp_ready = (exp_g >= 0 && (!m_valid || out_ready) && in_valid[exp_g]) ? N'(1) << exp_g : '0;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!m_valid || out_ready) begin
      if (exp_ready != 0) begin
        m_valid = 1;
        m_data  = in_data[exp_g*W +: W];
        m_sel   = exp_g;
        m_ptr   = (exp_g + 1) % N;
`ifdef ELBETH_MUX_ARB_LOCK_EN
        m_lock = in_lock[exp_g];
        if (in_lock[exp_g]) m_lock_ch = exp_g;
`endif
      end else m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = '0; in_lock = '0; out_ready = 1; mode = 0;
    v3 = '0; l3 = '0; or3 = 1; mode3 = 0; d3 = '0;
    @(negedge clk);
    rst = 0;
    m_ptr = 0; m_sel = 0; m_lock = 0; m_lock_ch = 0; m_valid = 0; m_data = '0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    mode = 1; in_valid = 4'b0100; in_data = {N{32'hDEAD_BEEF}}; out_ready = 0;
    settle(); advance();
    #2 rst = 1; #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0 || in_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%b data=%h sel=%0d ready=%b required 0/0/0/0", out_valid, out_data, out_sel, in_ready);
    end
    do_reset();
    @(negedge clk);
    mode = 1; in_valid = 4'b1111; out_ready = 1;
    settle();
    checks++;
    if (in_ready !== 4'b0001 || exp_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_rr: ready=%b required 0001", in_ready);
    end
    advance();
  endtask

  task automatic test_fixed();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mode = 0; in_valid = 4'b1010; out_ready = 1; in_data = {$urandom, $urandom, $urandom, $urandom};
      settle();
      checks++;
      if (in_ready !== 4'b0010 || in_ready !== exp_ready) begin
        errors++;
        $display("FAIL fixed_ready: got %b required 0010", in_ready);
      end
      advance();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== m_data) begin
        errors++;
        $display("FAIL fixed_out: valid=%b sel=%0d data=%h required 1/1/%h", out_valid, out_sel, out_data, m_data);
      end
    end
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA000_0000 + i;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mode = 1; in_valid = 4'b1111; out_ready = 1;
      settle();
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b required %b", c, in_ready, exp_ready);
      end
      advance();
      checks++;
      if (out_sel !== 2'(seq[c]) || out_data !== 32'hA000_0000 + seq[c] || out_valid !== 1'b1 || m_sel != seq[c]) begin
        errors++;
        $display("FAIL rr_out[%0d]: sel=%0d data=%h required %0d/%h", c, out_sel, out_data, seq[c], 32'hA000_0000 + seq[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held_d;
    logic [1:0]   held_s;
    @(negedge clk);
    mode = 1; in_valid = 4'b1111; out_ready = 1;
    settle(); advance();
    held_d = out_data; held_s = out_sel;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 0; in_data = {$urandom, $urandom, $urandom, $urandom};
      settle();
      checks++;
      if (in_ready !== 4'b0 || exp_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b required 0000", c, in_ready);
      end
      advance();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_d || out_sel !== held_s) begin
        errors++;
        $display("FAIL bp_hold[%0d]: data=%h sel=%0d required %h/%0d", c, out_data, out_sel, held_d, held_s);
      end
    end
    @(negedge clk);
    out_ready = 1;
    settle();
    checks++;
    if (in_ready === 4'b0 || in_ready !== exp_ready) begin
      errors++;
      $display("FAIL bp_release_ready: got %b required %b", in_ready, exp_ready);
    end
    advance();
    checks++;
    if (out_valid !== 1'b1 || out_data !== m_data || out_sel !== 2'(m_sel)) begin
      errors++;
      $display("FAIL bp_release_out: valid=%b data=%h required 1/%h", out_valid, out_data, m_data);
    end
    @(negedge clk);
    in_valid = '0;
    settle(); advance();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_wrap_sparse();
    do_reset();
    @(negedge clk);
    mode3 = 1; v3 = 3'b010; d3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}; or3 = 1;
    @(negedge clk);
    v3 = 3'b001; #1;
    checks++;
    if (r3 !== 3'b001) begin
      errors++;
      $display("FAIL wrap_grant: got %b required 001", r3);
    end
    @(negedge clk);
    checks++;
    if (ov3 !== 1'b1 || s3 !== 2'd0 || od3 !== 32'h1111_1111) begin
      errors++;
      $display("FAIL wrap_out: sel=%0d data=%h required 0/11111111", s3, od3);
    end
    v3 = 3'b111; #1;
    checks++;
    if (r3 !== 3'b010) begin
      errors++;
      $display("FAIL wrap_ptr: got %b required 010", r3);
    end
    @(negedge clk);
    v3 = '0;
  endtask

`ifdef ELBETH_MUX_ARB_LOCK_EN
  task automatic test_lock();
    logic [0:2] lk = 3'b110;
    do_reset();
    @(negedge clk);
    mode = 1; in_valid = 4'b0010; out_ready = 1;
    settle(); advance();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      in_valid = 4'b1111; in_data = {$urandom, $urandom, $urandom, $urandom};
      in_lock = (b < 3 && lk[b]) ? 4'b0100 : 4'b0000;
      settle();
      advance();
      checks++;
      if (out_sel !== ((b < 3) ? 2'd2 : 2'd3) || out_data !== m_data) begin
        errors++;
        $display("FAIL lock_beat[%0d]: sel=%0d data=%h required %0d/%h", b, out_sel, out_data, (b < 3) ? 2 : 3, m_data);
      end
    end
    in_lock = '0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid  = 4'($urandom);
      mode      = (c / 50) % 2 == 1;
      out_ready = $urandom_range(0, 3) != 0;
      in_lock   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      settle();
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b required %b", c, in_ready, exp_ready);
      end
      advance();
      checks++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== 2'(m_sel)))) begin
        errors++;
        $display("FAIL rand_out[%0d]: v=%b d=%h s=%0d required %b/%h/%0d", c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
  endtask

  initial begin
    rst = 1; in_data = '0; in_valid = '0; in_lock = '0; mode = 0; out_ready = 1;
    d3 = '0; v3 = '0; l3 = '0; mode3 = 0; or3 = 1;
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_wrap_sparse();
`ifdef ELBETH_MUX_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/elbeth_mux_arb.md
# elbeth_mux_arb

Parametrised, registered N-channel data selector with valid/ready handshakes and built-in arbitration. It generalises the pipeline's 4-to-1 32-bit select into a sequential block that chooses among NUM_CH requesters, fixed-priority or round-robin. The choice is made by hardware, not by an external select, and the winning word is forwarded through one output register stage. It sits in front of the shared memory/bus port, where the fetch, load/store and debug paths contend for one 32-bit channel.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each data word
- NUM_CH, 4, number of input channels; legal range 2..16
- SEL_W, derived as $clog2(NUM_CH); localparam, not overridable

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  NUM_CH*DATA_WIDTH  packed channel words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  input  NUM_CH  per-channel request
- in_ready  output  NUM_CH  per-channel accept; one-hot or zero
- in_lock  input  NUM_CH  per-channel "hold grant after this beat"; used only with ELBETH_MUX_ARB_LOCK_EN
- mode  input  1  0 = fixed priority (channel 0 highest), 1 = round-robin
- out_data  output  DATA_WIDTH  registered selected word
- out_sel  output  SEL_W  registered index of the channel that produced out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  downstream accept

## Operation
- load = !out_valid | out_ready.
- Grant is computed combinationally from in_valid, mode, the rr pointer and the lock state.
- in_ready[g] = load & in_valid[g] for the granted channel g. All other bits are 0.
- in_ready depends combinationally on out_ready. This path is intended.
- A beat is accepted when in_valid[g] & in_ready[g]. On accept, out_data <= word g, out_sel <= g, out_valid <= 1.
- If load=1 and no channel is valid, out_valid <= 0.
- If load=0, out_data, out_sel and out_valid hold. out_data is stable while out_valid & !out_ready.
- Fixed mode: g = lowest index with in_valid set.
- Round-robin mode: g = first valid channel searched from ptr upward, wrapping NUM_CH-1 -> 0.
- ptr update: on every accept, ptr <= (g+1) mod NUM_CH, in both modes. ptr is otherwise unchanged.
- Changing mode takes effect at the next arbitration. No drain is required.
- If no channel is valid, no grant is issued and ptr holds.

## Timing
- Latency: 1 cycle from accept to out_valid/out_data.
- Throughput: 1 beat per cycle when out_ready is held high.
- Reset values (asynchronous assert, synchronous-edge release): out_valid=0, out_data=0, out_sel=0, ptr=0, lock_active=0, lock_ch=0.
- While rst=1, in_ready=0.
- Reset mid-transfer drops the registered word. No recovery is attempted.
- Accept and drain in the same cycle (out_valid=1, out_ready=1, new accept): the register is overwritten with the new word. out_valid stays 1.
- Drain with no new request: out_valid falls to 0 on the next edge.
- Grant is re-evaluated every cycle while load=0. The channel finally accepted is the one granted in the accept cycle; no grant is latched across stall cycles.
- NUM_CH not a power of two: ptr wraps at NUM_CH-1, never reaching unused codes.

## Configuration
- Macro ELBETH_MUX_ARB_LOCK_EN.
- Defined: lock is enabled.
  - On accept from g with in_lock[g]=1, set lock_active=1 and lock_ch=g.
  - While lock_active, the grant is forced to lock_ch and other channels see in_ready=0, even if lock_ch is not valid.
  - Accepting a beat from lock_ch with in_lock=0 clears lock_active. That beat is the last one of the locked burst.
  - ptr still updates on every accept.
- Undefined: in_lock is ignored, no lock state is synthesised, and arbitration is purely per-beat.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately; first post-reset RR grant goes to channel 0.
- Fixed priority: mode=0, in_valid=4'b1010, out_ready=1 -> ch1 accepted each cycle; out_sel=1; ch3 starved while ch1 is valid.
- Round-robin: mode=1, in_valid=4'b1111, out_ready=1, in_data ch i = 32'hA000_000i -> out_sel sequence 0,1,2,3,0 and out_data matches each channel's word, one per cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_sel stable and in_ready=0. Raise out_ready -> the next word is accepted the same cycle, and out_valid stays 1.
- Wrap and sparse: NUM_CH=3, mode=1, ptr=2, in_valid=3'b001 -> ch0 granted, ptr becomes 1.
- Lock (macro defined): mode=1, ch2 sends 3 beats with in_lock=1,1,0 while ch0, ch1 and ch3 are valid -> three consecutive out_sel=2. The next grant goes to ch3 (ptr=3).
